// File: rtl/fp_sum_pkg.sv
// -----------------------------------------------------------------------------
// fp_sum_pkg
// Shared definitions for the single-precision sum accumulator (fp_sum_acc):
//   - fp_sum_state_e : controller state enumeration (also exported on dbg_state)
//   - EXP_W/MAN_W/BIAS : IEEE-754 single-precision field widths and bias
//   - MANX_W : width of the extended working mantissa
//              {carry, hidden, 23-bit fraction, 2 guard bits}
//   - canonical quiet NaN, signed infinities and signed max-finite constants
//   - fp_is_zero : true for +/-0 and for denormals (flushed to zero)
// -----------------------------------------------------------------------------
package fp_sum_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;
    localparam int MANX_W = MAN_W + 4;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;
    localparam logic [31:0] FP_POS_MAX = 32'h7F7F_FFFF;
    localparam logic [31:0] FP_NEG_MAX = 32'hFF7F_FFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_IN = 3'd1,
        ALIGN   = 3'd2,
        ADD     = 3'd3,
        NORM    = 3'd4,
        DONE    = 3'd5
    } fp_sum_state_e;

    // Zero exponent covers both true zeros and denormals, which are flushed.
    function automatic logic fp_is_zero(input logic [31:0] v);
        return (v[30:23] == '0);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// -----------------------------------------------------------------------------
// fp_lzc
// Combinational 27-bit leading-zero counter used to normalise the sum.
// Ports:
//   val_i [26:0] : value to scan, bit 26 is the most significant
//   lz_o  [4:0]  : number of leading zeros (27 when val_i is zero)
// -----------------------------------------------------------------------------
module fp_lzc (
    input  logic [26:0] val_i,
    output logic [4:0]  lz_o
);

    // Scan from LSB upward so the highest set bit writes last and wins.
    always_comb begin
        lz_o = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (val_i[i]) begin
                lz_o = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fp_sum_acc.sv
// -----------------------------------------------------------------------------
// fp_sum_acc
// Sequential IEEE-754 single-precision accumulator. Sums a stream of terms
// one at a time (ALIGN -> ADD -> NORM per term, truncating) and flags the
// final sum, which feeds the divider as its divisor.
//
// Parameters:
//   CNT_W       : term counter width; at most 2^CNT_W-1 terms per sum
// Ports:
//   clk         : clock, all state changes on the rising edge
//   reset       : asynchronous active-high reset
//   start       : begin a new sum (honoured only in IDLE or DONE)
//   in_valid    : in_data / in_last are valid
//   in_data     : single-precision term
//   in_last     : current term is the last of the sum
//   in_ready    : block accepts a term this cycle
//   sum         : accumulator value (meaningful while sum_valid=1)
//   sum_valid   : sum is final; held until the next start or reset
//   term_count  : terms accepted since start
//   dbg_state   : current controller state
//
// Handshake: a term transfers on a rising edge where in_valid=1 and
// in_ready=1. in_ready depends only on the state (high in WAIT_IN), never on
// in_valid; in_valid is ignored whenever in_ready=0.
//
// Build option: FP_SUM_SPECIALS_EN enables NaN/Inf handling (NaN in, Inf-Inf
// -> quiet NaN, Inf+finite -> Inf, overflow -> signed Inf). Without it,
// exponent 255 is an ordinary finite exponent and overflow saturates to the
// signed max finite value.
// -----------------------------------------------------------------------------
module fp_sum_acc
    import fp_sum_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [31:0]      sum,
    output logic             sum_valid,
    output logic [CNT_W-1:0] term_count,
    output fp_sum_state_e    dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // Count value at which the incoming term is the last one that fits.
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

    fp_sum_state_e     state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       term_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q;

    // ALIGN stage results: larger-magnitude operand and shifted smaller one.
    logic [EXP_W-1:0]  big_e_q, big_e_d;
    logic              big_s_q, big_s_d;
    logic [MAN_W+2:0]  big_m_q, big_m_d;
    logic [MAN_W+2:0]  small_m_q, small_m_d;
    logic              sub_q, sub_d;
    logic              skip_q, skip_d;

    // ADD stage result, bit 26 is the carry out of the mantissa add.
    logic [MANX_W-1:0] sum_m_q, sum_m_d;

    logic              start_ok;
    logic              accept;

    assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
    assign accept     = in_valid && (state_q == WAIT_IN);

    assign in_ready   = (state_q == WAIT_IN);
    assign sum        = acc_q;
    assign sum_valid  = valid_q;
    assign term_count = cnt_q;
    assign dbg_state  = state_q;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)    state_d = WAIT_IN;
            WAIT_IN:    if (in_valid) state_d = ALIGN;
            ALIGN:      state_d = ADD;
            ADD:        state_d = NORM;
            NORM:       state_d = last_q ? DONE : WAIT_IN;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // ALIGN: pick the larger magnitude, shift the other right.
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] acc_e, trm_e, small_e, exp_diff;
    logic [MAN_W+2:0] acc_m, trm_m, small_m;
    logic [4:0]       shamt;

    always_comb begin
        acc_e = acc_q[30:23];
        trm_e = term_q[30:23];
        // Hidden bit restored; denormals flush to a zero mantissa.
        acc_m = fp_is_zero(acc_q)  ? '0 : {1'b1, acc_q[MAN_W-1:0], 2'b00};
        trm_m = fp_is_zero(term_q) ? '0 : {1'b1, term_q[MAN_W-1:0], 2'b00};

        if ({trm_e, trm_m} > {acc_e, acc_m}) begin
            big_e_d = trm_e;
            big_s_d = term_q[31];
            big_m_d = trm_m;
            small_e = acc_e;
            small_m = acc_m;
        end else begin
            big_e_d = acc_e;
            big_s_d = acc_q[31];
            big_m_d = acc_m;
            small_e = trm_e;
            small_m = trm_m;
        end

        exp_diff  = big_e_d - small_e;
        // Shifting by 26 already clears the 26-bit mantissa completely.
        shamt     = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
        small_m_d = small_m >> shamt;
        sub_d     = acc_q[31] ^ term_q[31];
        skip_d    = fp_is_zero(term_q);
    end

    // ------------------------------------------------------------------
    // ADD: magnitudes are ordered, so the difference is never negative.
    // ------------------------------------------------------------------
    always_comb begin
        sum_m_d = '0;
        if (sub_q) begin
            sum_m_d = {1'b0, big_m_q} - {1'b0, small_m_q};
        end else begin
            sum_m_d = {1'b0, big_m_q} + {1'b0, small_m_q};
        end
    end

    // ------------------------------------------------------------------
    // NORM: leading-zero normalise, truncate, handle range limits.
    // ------------------------------------------------------------------
    logic [4:0]        lz;
    logic signed [9:0] new_e;
    logic [MAN_W-1:0]  res_man;
    logic [31:0]       ovf_val;

    fp_lzc u_lzc (
        .val_i (sum_m_q),
        .lz_o  (lz)
    );

    // After shifting left by lz the leading one sits at bit 26, which is one
    // place above the hidden-bit position: hence the +1 on the exponent.
    always_comb begin
        new_e   = $signed({2'b00, big_e_q}) + 10'sd1 - $signed({5'b00000, lz});
        res_man = 23'((sum_m_q << lz) >> 3);
`ifdef FP_SUM_SPECIALS_EN
        ovf_val = big_s_q ? FP_NEG_INF : FP_POS_INF;
`else
        ovf_val = big_s_q ? FP_NEG_MAX : FP_POS_MAX;
`endif
    end

`ifdef FP_SUM_SPECIALS_EN
    logic acc_nan, acc_inf, trm_nan, trm_inf;

    always_comb begin
        acc_nan = (acc_q[30:23]  == 8'hFF) && (acc_q[MAN_W-1:0]  != '0);
        acc_inf = (acc_q[30:23]  == 8'hFF) && (acc_q[MAN_W-1:0]  == '0);
        trm_nan = (term_q[30:23] == 8'hFF) && (term_q[MAN_W-1:0] != '0);
        trm_inf = (term_q[30:23] == 8'hFF) && (term_q[MAN_W-1:0] == '0);
    end
`endif

    always_comb begin
        acc_d = acc_q;
`ifdef FP_SUM_SPECIALS_EN
        // Specials live in the accumulator itself, so they stay sticky.
        if (acc_nan || trm_nan) begin
            acc_d = FP_QNAN;
        end else if (acc_inf && trm_inf && (acc_q[31] != term_q[31])) begin
            acc_d = FP_QNAN;
        end else if (acc_inf) begin
            acc_d = acc_q;
        end else if (trm_inf) begin
            acc_d = term_q;
        end else
`endif
        if (skip_q) begin
            acc_d = acc_q;
        end else if (sum_m_q == '0) begin
            acc_d = 32'h0000_0000;
        end else if (new_e <= 10'sd0) begin
            acc_d = 32'h0000_0000;
        end else if (new_e >= 10'sd255) begin
            acc_d = ovf_val;
        end else begin
            acc_d = {big_s_q, new_e[7:0], res_man};
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            term_q    <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            big_e_q   <= '0;
            big_s_q   <= 1'b0;
            big_m_q   <= '0;
            small_m_q <= '0;
            sub_q     <= 1'b0;
            skip_q    <= 1'b0;
            sum_m_q   <= '0;
        end else begin
            if (start_ok) begin
                acc_q   <= '0;
                cnt_q   <= '0;
                valid_q <= 1'b0;
            end
            if (accept) begin
                term_q <= in_data;
                // Force completion when the counter would otherwise wrap.
                last_q <= in_last || (cnt_q == CNT_PRE);
                cnt_q  <= cnt_q + CNT_ONE;
            end
            if (state_q == ALIGN) begin
                big_e_q   <= big_e_d;
                big_s_q   <= big_s_d;
                big_m_q   <= big_m_d;
                small_m_q <= small_m_d;
                sub_q     <= sub_d;
                skip_q    <= skip_d;
            end
            if (state_q == ADD) begin
                sum_m_q <= sum_m_d;
            end
            if (state_q == NORM) begin
                acc_q <= acc_d;
                if (last_q) begin
                    valid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_sum_acc.sv
// -----------------------------------------------------------------------------
// tb_fp_sum_acc
// Directed bench for fp_sum_acc: a table of term sequences with hand-computed
// sums, followed by sequences for back-to-back streaming, reset in the middle
// of a sum, ignored start, and term-counter saturation.
// -----------------------------------------------------------------------------
module tb_fp_sum_acc;
    import fp_sum_pkg::*;

    localparam int CNT_W = 8;
    localparam int NV    = 14;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic [31:0]       sum;
    logic              sum_valid;
    logic [CNT_W-1:0]  term_count;
    fp_sum_state_e     dbg_state;

    always #5 clk = ~clk;

    fp_sum_acc #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .sum        (sum),
        .sum_valid  (sum_valid),
        .term_count (term_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        int          n;
        logic [31:0] t[4];
        logic [31:0] exp_sum;
    } vec_t;

    vec_t vec[NV];

    task automatic set_vec(input int idx, input string name, input int n,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] e);
        vec[idx].name    = name;
        vec[idx].n       = n;
        vec[idx].t[0]    = a;
        vec[idx].t[1]    = b;
        vec[idx].t[2]    = c;
        vec[idx].t[3]    = 32'h0;
        vec[idx].exp_sum = e;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_term(input logic [31:0] d, input logic l);
        int budget;
        budget   = 50;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 expected 1 for term %08h", d);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int budget;
        budget = 20;
        while (!sum_valid && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        checks++;
        if (!sum_valid) begin
            errors++;
            $display("FAIL %s_done_timeout: sum_valid=0 expected 1", name);
        end
    endtask

    logic [31:0] b2b[4];

    // ---------------- test body ----------------
    initial begin
        set_vec(0,  "sum_3p5",      3, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40600000);
        set_vec(1,  "neg_8",        2, 32'hC1500000, 32'h40A00000, 32'h0,        32'hC1000000);
        set_vec(2,  "cancel",       2, 32'h40200000, 32'hC0200000, 32'h0,        32'h00000000);
        set_vec(3,  "zero_only",    1, 32'h00000000, 32'h0,        32'h0,        32'h00000000);
        set_vec(4,  "denorm_flush", 2, 32'h00000001, 32'h3F800000, 32'h0,        32'h3F800000);
        set_vec(5,  "neg_zero",     2, 32'h3F800000, 32'h80000000, 32'h0,        32'h3F800000);
        set_vec(6,  "underflow",    2, 32'h00800000, 32'h80C00000, 32'h0,        32'h00000000);
        set_vec(7,  "trunc",        2, 32'h3F800000, 32'h33800000, 32'h0,        32'h3F800000);
        set_vec(8,  "carry",        2, 32'h3FC00000, 32'h3FC00000, 32'h0,        32'h40400000);
        set_vec(9,  "sub_lz",       2, 32'h3F800000, 32'hBF400000, 32'h0,        32'h3E800000);
`ifdef FP_SUM_SPECIALS_EN
        set_vec(10, "max_max",      2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0,        32'h7F800000);
        set_vec(11, "inf_fin",      2, 32'h7F800000, 32'h3F800000, 32'h0,        32'h7F800000);
        set_vec(12, "nan_in",       2, 32'h7F800001, 32'h3F800000, 32'h0,        32'h7FC00000);
        set_vec(13, "inf_minf",     2, 32'h7F800000, 32'hFF800000, 32'h0,        32'h7FC00000);
`else
        set_vec(10, "max_max",      2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0,        32'h7F7FFFFF);
        set_vec(11, "inf_fin",      2, 32'h7F800000, 32'h3F800000, 32'h0,        32'h7F7FFFFF);
        set_vec(12, "nan_in",       2, 32'h7F800001, 32'h3F800000, 32'h0,        32'h7F7FFFFF);
        // Exp-255 term clamps to max; then 2^128 - (2^128 - 2^104) = 2^104, negative.
        set_vec(13, "inf_minf",     2, 32'h7F800000, 32'hFF800000, 32'h0,        32'hF3800000);
`endif
        b2b[0] = 32'h3F800000;
        b2b[1] = 32'h40000000;
        b2b[2] = 32'h40800000;
        b2b[3] = 32'h41000000;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        #3;
        check("rst_sum",       sum,                32'h0);
        check("rst_sum_valid", 32'(sum_valid),     32'h0);
        check("rst_in_ready",  32'(in_ready),      32'h0);
        check("rst_count",     32'(term_count),    32'h0);
        check("rst_state",     32'(dbg_state),     32'(IDLE));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // ---- table-driven sums ----
        for (int r = 0; r < NV; r++) begin
            do_start();
            check($sformatf("%s_start_valid", vec[r].name), 32'(sum_valid),  32'h0);
            check($sformatf("%s_start_count", vec[r].name), 32'(term_count), 32'h0);
            for (int j = 0; j < vec[r].n; j++) begin
                send_term(vec[r].t[j], (j == vec[r].n - 1));
            end
            wait_done(vec[r].name);
            check($sformatf("%s_sum", vec[r].name),   sum,              vec[r].exp_sum);
            check($sformatf("%s_count", vec[r].name), 32'(term_count),  32'(vec[r].n));
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("%s_held", vec[r].name),  32'(sum_valid),   32'h1);
        end

        // ---- back-to-back: in_valid held high, 4 terms ----
        begin
            int k;
            int cyc;
            int last_acc;
            k        = 0;
            cyc      = 0;
            last_acc = 0;
            do_start();
            in_valid = 1'b1;
            in_data  = b2b[0];
            in_last  = 1'b0;
            while (k < 4 && cyc < 60) begin
                if (in_ready) begin
                    if (k > 0) check($sformatf("b2b_gap%0d", k), 32'(cyc - last_acc), 32'd4);
                    last_acc = cyc;
                    k++;
                    @(posedge clk); #1;
                    cyc++;
                    if (k < 4) begin
                        in_data = b2b[k];
                        in_last = (k == 3);
                    end
                end else begin
                    @(posedge clk); #1;
                    cyc++;
                end
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            check("b2b_accepted", 32'(k), 32'd4);
            wait_done("b2b");
            check("b2b_sum",   sum,             32'h41700000);
            check("b2b_count", 32'(term_count), 32'd4);
        end

        // ---- ignored start, then reset during ALIGN of the 2nd term ----
        do_start();
        send_term(32'h3F800000, 1'b0);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_start_count", 32'(term_count), 32'd1);
        check("ign_start_state", 32'(dbg_state),  32'(WAIT_IN));
        send_term(32'h40000000, 1'b0);
        check("mid_state_align", 32'(dbg_state),  32'(ALIGN));
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_sum",      sum,               32'h0);
        check("mid_rst_valid",    32'(sum_valid),    32'h0);
        check("mid_rst_in_ready", 32'(in_ready),     32'h0);
        check("mid_rst_count",    32'(term_count),   32'h0);
        check("mid_rst_state",    32'(dbg_state),    32'(IDLE));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(sum_valid), 32'h0);
        do_start();
        send_term(32'h3F000000, 1'b1);
        wait_done("post_rst");
        check("post_rst_sum",   sum,             32'h3F000000);
        check("post_rst_count", 32'(term_count), 32'd1);

        // ---- counter saturation: 255 terms of 1.0, in_last never set ----
        do_start();
        for (int i = 0; i < 255; i++) begin
            send_term(32'h3F800000, 1'b0);
        end
        wait_done("wrap");
        check("wrap_sum",   sum,             32'h437F0000);
        check("wrap_count", 32'(term_count), 32'd255);
        check("wrap_state", 32'(dbg_state),  32'(DONE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_sum_acc.md
FP_SUM_ACC -- requirements
Module: fp_sum_acc

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the term counter; up to 2^CNT_W-1 terms per sum.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: begin a new sum; sampled only in IDLE or DONE.
REQ-005 SHALL have port in_valid, input, 1: in_data and in_last are valid.
REQ-006 SHALL have port in_data, input, 32: IEEE-754 single-precision term.
REQ-007 SHALL have port in_last, input, 1: the current term is the final term of the sum.
REQ-008 SHALL have port in_ready, output, 1: the block accepts a term this cycle.
REQ-009 SHALL have port sum, output, 32: accumulated single-precision sum, i.e. the divisor fed to fp_div_v3.
REQ-010 SHALL have port sum_valid, output, 1: sum is final; held high until the next start or reset.
REQ-011 SHALL have port term_count, output, CNT_W: number of terms accepted since start.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_IN, ALIGN, ADD, NORM, DONE.
REQ-013 SHALL move IDLE/DONE -> WAIT_IN on start=1, clearing the accumulator to +0, term_count to 0 and sum_valid to 0.
REQ-014 SHALL drive in_ready=1 only in WAIT_IN; a term is accepted when in_valid=1 and in_ready=1.
REQ-015 SHALL move WAIT_IN -> ALIGN on acceptance, latching in_data and in_last and incrementing term_count.
REQ-016 SHALL, in ALIGN, right-shift the mantissa (hidden bit restored) of the smaller-exponent operand by the exponent difference, with the shift saturating at 26.
REQ-017 SHALL, in ADD, add the mantissas on equal signs; on differing signs, subtract the smaller magnitude from the larger and take the sign of the larger.
REQ-018 SHALL, in NORM, normalise in one cycle using a leading-zero count, adjust the exponent, truncate (round toward zero), and write the accumulator.
REQ-019 SHALL move NORM -> WAIT_IN if the latched last flag=0, else NORM -> DONE with sum_valid=1; the per-term occupancy is therefore exactly 4 cycles from acceptance to the next in_ready.
REQ-020 SHALL flush denormal inputs to zero; a zero operand SHALL leave the accumulator unchanged, except that adding zero to the initial +0 yields +0.
REQ-021 SHALL produce +0 (0x00000000) on exact cancellation.
REQ-022 SHALL flush results with exponent underflow to +0.
REQ-023 SHALL ignore start outside IDLE/DONE.
REQ-024 SHALL ignore in_valid outside WAIT_IN.
REQ-025 SHALL, if term_count would wrap, force DONE after the 2^CNT_W-1th term regardless of in_last.
REQ-026 SHALL drive sum continuously from the accumulator; sum is meaningful only while sum_valid=1.

Reset
REQ-027 SHALL, on reset=1, immediately set state IDLE, sum=0, sum_valid=0, in_ready=0, term_count=0.
REQ-028 SHALL discard any in-flight sum on reset mid-operation; no partial result is flagged valid.

Configuration
REQ-029 SHALL, with FP_SUM_SPECIALS_EN defined, handle special values as follows: NaN in any input gives 0x7FC00000; Inf+finite gives that Inf; +Inf + -Inf gives 0x7FC00000; exponent overflow gives signed Inf; these results are sticky until DONE.
REQ-030 SHALL, without FP_SUM_SPECIALS_EN, treat exponent 255 as an ordinary finite exponent and saturate overflow to signed max finite (0x7F7FFFFF / 0xFF7FFFFF).

Structure
REQ-031 SHALL take from a shared package fp_sum_pkg: the state enumeration, the field widths (EXP_W=8, MAN_W=23, BIAS=127) and the canonical NaN/Inf/max-finite constants.
REQ-032 SHALL use one sub-module, fp_lzc: a combinational 27-bit leading-zero counter used by NORM.

Verification
REQ-033 SHALL cover: start; terms 0x3F800000, 0x40000000, 0x3F000000 (last) -> sum=0x40600000 (3.5), sum_valid=1, term_count=3.
REQ-034 SHALL cover: terms 0xC1500000 (-13), 0x40A00000 (+5, last) -> sum=0xC1000000 (-8).
REQ-035 SHALL cover: terms 0x40200000, 0xC0200000 (last) -> sum=0x00000000.
REQ-036 SHALL cover: in_valid held high with 4 terms -> in_ready high exactly once per 4 cycles, and no term is lost or duplicated.
REQ-037 SHALL cover: reset asserted during ALIGN of the 2nd term -> outputs reach reset values without waiting for a clock edge; a new start then sums correctly from +0.
REQ-038 SHALL cover: with FP_SUM_SPECIALS_EN defined, terms 0x7F800000, 0x3F800000 (last) -> 0x7F800000; without the macro, terms 0x7F7FFFFF, 0x7F7FFFFF -> 0x7F7FFFFF.
